// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for an RV32I integer subset.
// Walks each accepted instruction through FETCH, DECODE, EXECUTE, optional MEM
// and WRITEBACK (or TRAP for unsupported encodings) and drives registered
// datapath controls.
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   instr_valid, instr   instruction handshake input
//   instr_ready          high only while waiting in FETCH (low during reset)
//   mem_ready            data memory completion, honoured only in MEM
//   alu_zero             ALU zero flag, sampled in EXECUTE
//   rs1, rs2, rd         register indices of the latched instruction
//   immediate            sign-extended immediate (zero-extended shamt for shifts)
//   alu_op               ALU operation code
//   reg_or_immediate     1 selects rs2 as second ALU operand
//   limit_immediate      1 marks a shift-immediate operand
//   reg_write, data_mem_read, data_mem_write, pc_write, pc_src   strobes
//   illegal_instr        one-cycle pulse for unsupported encodings
//   retire_count         completed-instruction counter (wraps)
module multicycle_control_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            mem_ready,
  input  logic            alu_zero,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] immediate,
  output logic [3:0]      alu_op,
  output logic            reg_or_immediate,
  output logic            limit_immediate,
  output logic            reg_write,
  output logic            data_mem_read,
  output logic            data_mem_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            illegal_instr,
  output logic [31:0]     retire_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_LUI
  } iclass_t;

  state_t      state, state_n;
  iclass_t     cls, dec_cls;
  logic [31:0] instr_q;

  logic        reg_write_n, data_mem_read_n, data_mem_write_n;
  logic        pc_write_n, taken, taken_n, illegal_n;
  logic [31:0] retire_n;

  logic            dec_illegal, dec_roi, dec_lim;
  logic [3:0]      dec_op, f3_op;
  logic [XLEN-1:0] dec_imm;
  logic signed [31:0] imm32;

  wire [6:0] opcode = instr_q[6:0];
  wire [2:0] f3     = instr_q[14:12];
  wire [6:0] f7     = instr_q[31:25];

  // Immediate formats, sign-extended to 32 bits before widening to XLEN
  wire signed [31:0] i_imm = {{20{instr_q[31]}}, instr_q[31:20]};
  wire signed [31:0] s_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  wire signed [31:0] b_imm = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                              instr_q[11:8], 1'b0};
  wire signed [31:0] u_imm = {instr_q[31:12], 12'b0};

  assign instr_ready = resetn && (state == S_FETCH);
  assign pc_src      = taken;

  // func3 to ALU operation shared by R-type and I-ALU
  always_comb begin
    f3_op = ALU_ADD;
    case (f3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  // Instruction decode of the latched word
  always_comb begin
    dec_illegal = 1'b0;
    dec_cls     = C_ALU;
    dec_op      = ALU_ADD;
    dec_roi     = 1'b0;
    dec_lim     = 1'b0;
    imm32       = i_imm;
    case (opcode)
      OP_R: begin
        dec_roi = 1'b1;
        if (f7 == 7'b0000000) begin
          dec_op = f3_op;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec_op = ALU_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec_op = f3_op;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_lim = 1'b1;
          if (f3 == 3'b101 && instr_q[30]) dec_op = ALU_SRA;
        end
      end
      OP_LOAD:  dec_cls = C_LOAD;
      OP_STORE: begin
        dec_cls = C_STORE;
        imm32   = s_imm;
      end
      OP_BRANCH: begin
        dec_cls = C_BRANCH;
        dec_op  = ALU_SUB;
        dec_roi = 1'b1;
        imm32   = b_imm;
        // only BEQ and BNE are supported
        if (f3[2:1] != 2'b00) dec_illegal = 1'b1;
      end
      OP_LUI: begin
        dec_cls = C_LUI;
        imm32   = u_imm;
      end
      default: dec_illegal = 1'b1;
    endcase
    dec_imm = dec_lim ? XLEN'(instr_q[20 +: SHAMT_W]) : XLEN'(imm32);
  end

  wire writes_rd = (cls == C_ALU || cls == C_LOAD || cls == C_LUI) && (rd != 5'd0);

  // Next state and next registered strobe values
  always_comb begin
    state_n          = state;
    reg_write_n      = 1'b0;
    data_mem_read_n  = 1'b0;
    data_mem_write_n = 1'b0;
    pc_write_n       = 1'b0;
    taken_n          = 1'b0;
    illegal_n        = 1'b0;
    retire_n         = retire_count;
    case (state)
      S_FETCH: begin
        if (instr_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_n    = S_TRAP;
          illegal_n  = 1'b1;
          pc_write_n = 1'b1;
        end else begin
          state_n = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (cls == C_LOAD || cls == C_STORE) begin
          state_n          = S_MEM;
          data_mem_read_n  = (cls == C_LOAD);
          data_mem_write_n = (cls == C_STORE);
        end else begin
          state_n     = S_WRITEBACK;
          pc_write_n  = 1'b1;
          reg_write_n = writes_rd;
          taken_n     = (cls == C_BRANCH) && (alu_zero ^ instr_q[12]);
          retire_n    = retire_count + 32'd1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_n     = S_WRITEBACK;
          pc_write_n  = 1'b1;
          reg_write_n = writes_rd;
          retire_n    = retire_count + 32'd1;
        end else begin
          data_mem_read_n  = data_mem_read;
          data_mem_write_n = data_mem_write;
        end
      end
      default: state_n = S_FETCH;
    endcase
  end

  // State, latched instruction, decoded fields and registered strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= S_FETCH;
      instr_q          <= '0;
      cls              <= C_ALU;
      rs1              <= '0;
      rs2              <= '0;
      rd               <= '0;
      immediate        <= '0;
      alu_op           <= '0;
      reg_or_immediate <= 1'b0;
      limit_immediate  <= 1'b0;
      reg_write        <= 1'b0;
      data_mem_read    <= 1'b0;
      data_mem_write   <= 1'b0;
      pc_write         <= 1'b0;
      taken            <= 1'b0;
      illegal_instr    <= 1'b0;
      retire_count     <= '0;
    end else begin
      state          <= state_n;
      reg_write      <= reg_write_n;
      data_mem_read  <= data_mem_read_n;
      data_mem_write <= data_mem_write_n;
      pc_write       <= pc_write_n;
      taken          <= taken_n;
      illegal_instr  <= illegal_n;
      retire_count   <= retire_n;
      if (state == S_FETCH && instr_valid) instr_q <= instr;
      if (state == S_DECODE) begin
        cls              <= dec_cls;
        rs1              <= instr_q[19:15];
        rs2              <= instr_q[24:20];
        rd               <= instr_q[11:7];
        immediate        <= dec_imm;
        alu_op           <= dec_op;
        reg_or_immediate <= dec_roi;
        limit_immediate  <= dec_lim;
      end
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter XLEN, 32, datapath/immediate width; legal values 32 or 64.
REQ-002 Parameter SHAMT_W, $clog2(XLEN), shift-amount width used when limit_immediate=1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 instr_valid  input  1  instruction word available on instr.
REQ-006 instr  input  32  RV32I-encoded instruction.
REQ-007 instr_ready  output  1  block accepts instr this cycle.
REQ-008 mem_ready  input  1  data memory completed current access.
REQ-009 alu_zero  input  1  ALU result equals zero (valid in EXECUTE).
REQ-010 rs1, rs2, rd  output  5 each  register indices of latched instruction.
REQ-011 immediate  output  XLEN  sign-extended immediate (zero-extended shamt when limit_immediate=1).
REQ-012 alu_op  output  4  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
REQ-013 reg_or_immediate, limit_immediate  output  1 each  1=rs2 operand / 1=shift immediate.
REQ-014 reg_write, data_mem_read, data_mem_write, pc_write, pc_src  output  1 each  strobes; pc_src 1=branch target.
REQ-015 illegal_instr  output  1  one-cycle pulse on unsupported opcode/func.
REQ-016 retire_count  output  32  count of completed instructions.

Function
REQ-017 FSM states FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; instr_ready=1 only in FETCH.
REQ-018 FETCH: on instr_valid&&instr_ready, latch instr into internal register, go DECODE; else stay.
REQ-019 DECODE (1 cycle): register all decoded fields; supported opcodes 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BEQ/BNE, 0110111 LUI; otherwise go TRAP.
REQ-020 Decoded outputs (rs*, rd, immediate, alu_op, reg_or_immediate, limit_immediate) SHALL remain stable from DECODE exit until return to FETCH.
REQ-021 R-type: func7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND per func3; func7 0100000 with func3 000 -> SUB, 101 -> SRA; other func7 -> TRAP.
REQ-022 I-ALU: func3 maps as R-type excluding SUB; func3 001/101 set limit_immediate=1, immediate=instr[24:20] zero-extended to XLEN; instr[30]=1 with func3 101 -> SRA.
REQ-023 reg_or_immediate=1 for R-type and branch, 0 otherwise; LOAD/STORE/LUI use alu_op ADD; branch uses SUB.
REQ-024 Immediates: I instr[31:20], S {instr[31:25],instr[11:7]}, B {instr[31],instr[7],instr[30:25],instr[11:8],0}, U {instr[31:12],12'b0}; all sign-extended from bit 31 to XLEN.
REQ-025 EXECUTE (1 cycle): LOAD/STORE -> MEM; all others -> WRITEBACK; branch latches taken = alu_zero XOR func3[0].
REQ-026 MEM: data_mem_read (LOAD) or data_mem_write (STORE) held high every cycle until mem_ready=1; on mem_ready LOAD -> WRITEBACK, STORE -> WRITEBACK; no timeout.
REQ-027 WRITEBACK (1 cycle): reg_write=1 for R, I-ALU, LOAD, LUI when rd!=0; pc_write=1 always; pc_src=taken for branch else 0; retire_count increments by 1; next FETCH.
REQ-028 TRAP (1 cycle): illegal_instr=1, pc_write=1, pc_src=0, reg_write=0, retire_count unchanged; next FETCH.
REQ-029 Strobes (reg_write, pc_write, data_mem_*, illegal_instr) SHALL be 0 in all states not listed above.
REQ-030 retire_count wraps from 32'hFFFFFFFF to 0 without flag.
REQ-031 Minimum latency: ALU/branch/LUI 4 cycles FETCH-accept to FETCH; LOAD/STORE 5 cycles plus mem_ready wait cycles.
REQ-032 mem_ready outside MEM SHALL be ignored.

Reset
REQ-033 resetn=0 SHALL immediately force state FETCH, clear instruction register, retire_count, taken, and drive every output 0 except instr_ready.
REQ-034 instr_ready SHALL be 0 while resetn=0 and 1 in the first cycle after deassertion.
REQ-035 Reset asserted mid-MEM SHALL drop data_mem_read/data_mem_write asynchronously with no completion or retire.

Verification
REQ-036 add x3,x1,x2 (0x002081B3) -> DECODE next, EXECUTE alu_op=0, WRITEBACK reg_write=1 rd=3, retire_count=1, 4 cycles total.
REQ-037 srai x5,x6,3 (0x40335293) -> alu_op=7, limit_immediate=1, immediate=3, reg_or_immediate=0.
REQ-038 lw x4,-4(x2) (0xFFC12203), mem_ready low 3 cycles -> data_mem_read high 4 cycles, immediate=0xFFFFFFFC, reg_write in WRITEBACK.
REQ-039 bne x1,x2,+8 (0x00209463) with alu_zero=0 -> alu_op=1, pc_write=1, pc_src=1, reg_write=0.
REQ-040 opcode 0x0000007F -> TRAP, illegal_instr one-cycle pulse, retire_count unchanged, back to FETCH.
REQ-041 resetn low during STORE MEM wait -> data_mem_write=0 same cycle, FETCH, retire_count=0 after release.
